// File: rtl/serial_add_sub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM state codes,
// operation codes and the counter-width helper.
package serial_add_sub_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Equivalent of $clog2, kept as a plain loop so older tools accept it; at least 1 bit.
  function automatic int cnt_width(input int w);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < w) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_add_sub_full_adder.sv
// Single full-adder bit cell; the serial datapath reuses it once per clock.
module serial_add_sub_full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial WIDTH-bit adder/subtractor, LSB first, one bit per clock.
// Define SERIAL_OVF_EN to enable the signed-overflow flag; otherwise ovf is tied to 0.
module serial_add_sub
  import serial_add_sub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic               fa_s, fa_c;
  logic               last_bit;

  serial_add_sub_full_adder u_fa (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_c)
  );

  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

`ifdef SERIAL_OVF_EN
  logic ovf_q, ovf_d;
`endif

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
`ifdef SERIAL_OVF_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          // Subtraction is a + ~b + 1: invert b and seed the carry with 1.
          a_sh_d  = a;
          b_sh_d  = (sub == OP_SUB) ? ~b : b;
          carry_d = (sub == OP_SUB);
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        carry_d  = fa_c;
        result_d = {fa_s, result_q[WIDTH-1:1]};
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (last_bit) begin
          // Capture flags at the final bit so they are valid alongside done.
          cout_d  = fa_c;
`ifdef SERIAL_OVF_EN
          ovf_d   = carry_q ^ fa_c;
`endif
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
`ifdef SERIAL_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
`ifdef SERIAL_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy   = (state_q != ST_IDLE);
  assign done   = (state_q == ST_DONE);
  assign result = result_q;
  assign cout   = cout_q;
`ifdef SERIAL_OVF_EN
  assign ovf    = ovf_q;
`else
  assign ovf    = 1'b0;
`endif

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed bench for serial_add_sub (WIDTH=4) with an arithmetic reference model.
module tb_serial_add_sub;

  localparam int W = 4;
  localparam int M = 1 << W;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, cout, ovf;
  logic [W-1:0] result;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference model: phase 0 = idle, 1..W = run cycles, W+1 = done cycle.
  int           m_phase = 0;
  logic [W-1:0] m_res = '0, p_res = '0;
  logic         m_cout = 1'b0, p_cout = 1'b0;
  logic         m_ovf = 1'b0, p_ovf = 1'b0;

  serial_add_sub #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .sub    (sub),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    int sa, sb, exact;
    if (rst) begin
      m_phase = 0;
      m_res   = '0;
      m_cout  = 1'b0;
      m_ovf   = 1'b0;
    end else if (m_phase == 0) begin
      if (start) begin
        m_phase = 1;
        sa = (int'(a) >= M/2) ? int'(a) - M : int'(a);
        sb = (int'(b) >= M/2) ? int'(b) - M : int'(b);
        if (sub) begin
          p_res  = W'((int'(a) - int'(b) + M) % M);
          p_cout = (int'(a) >= int'(b));
          exact  = sa - sb;
        end else begin
          p_res  = W'((int'(a) + int'(b)) % M);
          p_cout = ((int'(a) + int'(b)) >= M);
          exact  = sa + sb;
        end
`ifdef SERIAL_OVF_EN
        p_ovf = (exact < -(M/2)) || (exact > M/2 - 1);
`else
        p_ovf = 1'b0;
`endif
      end
    end else if (m_phase == W + 1) begin
      m_phase = 0;
    end else begin
      m_phase++;
      if (m_phase == W + 1) begin
        m_res  = p_res;
        m_cout = p_cout;
        m_ovf  = p_ovf;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model busy", int'(busy), int'(m_phase != 0));
      check("model done", int'(done), int'(m_phase == W + 1));
      if (m_phase == 0 || m_phase == W + 1) begin
        check("model result", int'(result), int'(m_res));
        check("model cout", int'(cout), int'(m_cout));
        check("model ovf", int'(ovf), int'(m_ovf));
      end
    end
  end

  // One operation: drive start for one cycle, measure done latency and busy length.
  task automatic do_op(input string nm, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic isub, input logic [W-1:0] er, input logic ec,
                       input logic eo);
    int n, nb;
    logic eo_x;
`ifdef SERIAL_OVF_EN
    eo_x = eo;
`else
    eo_x = 1'b0;
`endif
    a = ia; b = ib; sub = isub; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    nb = busy ? 1 : 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
      if (busy) nb++;
    end
    check({nm, " latency"}, n, W + 1);
    check({nm, " busy cycles"}, nb, W + 1);
    check({nm, " result"}, int'(result), int'(er));
    check({nm, " cout"}, int'(cout), int'(ec));
    check({nm, " ovf"}, int'(ovf), int'(eo_x));
    $display("op %s: a=%0d b=%0d sub=%0d result=%0d cout=%0d ovf=%0d latency=%0d",
             nm, ia, ib, isub, result, cout, ovf, n);
    @(negedge clk);
  endtask

  initial begin
    int ndone, nwait;
    int dn[$];

    // Reset state
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset result", int'(result), 0);
    check("reset cout", int'(cout), 0);
    check("reset ovf", int'(ovf), 0);
    rst = 1'b0;
    @(negedge clk);

    do_op("add5+3", 4'd5, 4'd3, 1'b0, 4'd8, 1'b0, 1'b1);
    do_op("add9+8", 4'd9, 4'd8, 1'b0, 4'd1, 1'b1, 1'b1);
    do_op("add7+1", 4'd7, 4'd1, 1'b0, 4'd8, 1'b0, 1'b1);
    do_op("sub7-2", 4'd7, 4'd2, 1'b1, 4'd5, 1'b1, 1'b0);
    do_op("sub2-7", 4'd2, 4'd7, 1'b1, 4'd11, 1'b0, 1'b0);
    do_op("sub6-6", 4'd6, 4'd6, 1'b1, 4'd0, 1'b1, 1'b0);

    // Start pulsed again during RUN must be ignored
    a = 4'd1; b = 4'd1; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    a = 4'd15;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        check("ignore-start result", int'(result), 2);
      end
    end
    check("ignore-start done count", ndone, 1);
    $display("op ignore-start: dones=%0d result=%0d", ndone, result);
    do_op("after-ignore 2+3", 4'd2, 4'd3, 1'b0, 4'd5, 1'b0, 1'b0);

    // Reset in the 2nd RUN cycle aborts without done
    a = 4'd9; b = 4'd4; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort busy", int'(busy), 0);
    check("abort result", int'(result), 0);
    check("abort cout", int'(cout), 0);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort done count", ndone, 0);
    $display("op abort: dones=%0d result=%0d", ndone, result);
    do_op("after-abort 4+5", 4'd4, 4'd5, 1'b0, 4'd9, 1'b0, 1'b1);

    // Start held high: back-to-back ops every W+2 cycles
    a = 4'd3; b = 4'd4; sub = 1'b0; start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin
        dn.push_back(i);
        check("held result", int'(result), 7);
      end
    end
    start = 1'b0;
    check("held done count", dn.size(), 3);
    if (dn.size() >= 1) check("held first done", dn[0], W);
    for (int i = 1; i < dn.size(); i++) check("held interval", dn[i] - dn[i-1], W + 2);
    $display("op held-start: dones=%0d result=%0d", dn.size(), result);
    nwait = 0;
    while (busy && nwait < 20) begin
      @(negedge clk);
      nwait++;
    end
    check("held drain", int'(busy), 0);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
